// File: rtl/mem_map_pkg.sv
// Shared address map, access-size codes and decode helpers for the MEM-stage
// data responder and its MMIO sub-blocks.
package mem_map_pkg;

    // Default base of the 256-byte MMIO window
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    // MMIO register offsets within the window
    localparam logic [7:0] OFF_TIME_LO   = 8'h00;
    localparam logic [7:0] OFF_TIME_HI   = 8'h04;
    localparam logic [7:0] OFF_CMP_LO    = 8'h08;
    localparam logic [7:0] OFF_CMP_HI    = 8'h0C;
    localparam logic [7:0] OFF_TOHOST    = 8'h10;
    localparam logic [7:0] OFF_LOAD_CYC  = 8'h14;
    localparam logic [7:0] OFF_STORE_CYC = 8'h18;

    // Size codes carried on MEM_write_i (doubling as the unshifted byte-enable)
    localparam logic [3:0] SZ_LOAD = 4'b0000;
    localparam logic [3:0] SZ_B    = 4'b0001;
    localparam logic [3:0] SZ_H    = 4'b0011;
    localparam logic [3:0] SZ_W    = 4'b1111;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_MMIO = 2'd1,
        REG_NONE = 2'd2
    } region_t;

    // Data mask covering the bytes a store of the given size touches (LSB-aligned)
    function automatic logic [31:0] size_mask(input logic [3:0] sz);
        logic [31:0] m;
        case (sz)
            SZ_B:    m = 32'h0000_00FF;
            SZ_H:    m = 32'h0000_FFFF;
            SZ_W:    m = 32'hFFFF_FFFF;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    // A store is misaligned when it would straddle its natural boundary
    function automatic logic is_misaligned(input logic [3:0] sz, input logic [1:0] a10);
        logic r;
        case (sz)
            SZ_H:    r = a10[0];
            SZ_W:    r = (a10 != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// 64-bit free-running machine timer with compare register and registered
// interrupt. The interrupt compares against the compare value held before
// any write in the same cycle, so a CMP write takes effect one cycle later.
module mmio_timer
    import mem_map_pkg::*;
(
    input  logic        clk,
    input  logic        rst_i,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    input  logic [1:0]  rd_sel,
    output logic [31:0] rdata,
    output logic        timer_irq_o
);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_irq;

    // Timer count, compare register updates and interrupt compare
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_irq      <= 1'b0;
        end else begin
            r_mtime <= r_mtime + 64'd1;
            r_irq   <= (r_mtime >= r_mtimecmp);
            if (wr_lo) begin
                r_mtimecmp[31:0] <= wdata;
            end
            if (wr_hi) begin
                r_mtimecmp[63:32] <= wdata;
            end
        end
    end

    // Live read-back selected by word offset within the timer registers
    always_comb begin
        rdata = 32'd0;
        case (rd_sel)
            2'd0:    rdata = r_mtime[31:0];
            2'd1:    rdata = r_mtime[63:32];
            2'd2:    rdata = r_mtimecmp[31:0];
            2'd3:    rdata = r_mtimecmp[63:32];
            default: rdata = 32'd0;
        endcase
    end

    assign timer_irq_o = r_irq;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's MEM-stage data port: word RAM plus a
// small MMIO window (timer, compare/irq, tohost exit register). Read data is
// combinational so the core latches it in the access cycle; errors are
// reported one cycle later on err_o.
// Optional feature macro: MEM_STATS_EN adds saturating LOAD_CYC/STORE_CYC
// counters at MMIO +0x14/+0x18 (otherwise those offsets are unmapped).
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int          RAM_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter              INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        MEM_en_i,
    input  logic [31:0] MEM_addr_i,
    input  logic [31:0] MEM_data_i,
    input  logic [3:0]  MEM_write_i,
    output logic [31:0] MEM_data_o,
    output logic        err_o,
    output logic        timer_irq_o,
    output logic        done_o,
    output logic [31:0] exit_code_o
);

    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

    logic [31:0] r_ram [RAM_WORDS];

    logic        r_err;
    logic        r_done;
    logic [31:0] r_exit_code;

    region_t          w_region;
    logic             w_is_load;
    logic             w_is_store;
    logic             w_bad_size;
    logic             w_misaligned;
    logic             w_mmio_size_ok;
    logic [7:0]       w_offset;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [31:0]      w_ram_shifted;
    logic [3:0]       w_byte_en;
    logic [31:0]      w_wdata_shifted;
    logic [31:0]      w_timer_rdata;

    logic [31:0] w_rdata;
    logic        w_err;
    logic        w_ram_we;
    logic        w_cmp_lo_we;
    logic        w_cmp_hi_we;
    logic        w_tohost_we;
    logic        w_load_hit;
    logic        w_store_hit;

    assign w_is_load      = (MEM_write_i == SZ_LOAD);
    assign w_is_store     = (MEM_write_i == SZ_B) || (MEM_write_i == SZ_H) || (MEM_write_i == SZ_W);
    assign w_bad_size     = !(w_is_load || w_is_store);
    assign w_misaligned   = is_misaligned(MEM_write_i, MEM_addr_i[1:0]);
    assign w_mmio_size_ok = (w_is_load || (MEM_write_i == SZ_W)) && (MEM_addr_i[1:0] == 2'b00);
    assign w_offset       = MEM_addr_i[7:0];
    assign w_ram_idx      = MEM_addr_i[RAM_AW+1:2];
    assign w_ram_shifted  = r_ram[w_ram_idx] >> {MEM_addr_i[1:0], 3'b000};
    assign w_byte_en      = 4'(MEM_write_i << MEM_addr_i[1:0]);
    assign w_wdata_shifted = MEM_data_i << {MEM_addr_i[1:0], 3'b000};

    // Region decode: RAM at the bottom of the address space, MMIO window at MMIO_BASE
    always_comb begin
        w_region = REG_NONE;
        if ({1'b0, MEM_addr_i} < RAM_BYTES) begin
            w_region = REG_RAM;
        end else if (MEM_addr_i[31:8] == MMIO_BASE[31:8]) begin
            w_region = REG_MMIO;
        end else begin
            w_region = REG_NONE;
        end
    end

`ifdef MEM_STATS_EN
    logic [31:0] r_load_cyc;
    logic [31:0] r_store_cyc;
`endif

    // Access decode: read data mux, write strobes and error classification
    always_comb begin
        w_rdata     = 32'd0;
        w_err       = 1'b0;
        w_ram_we    = 1'b0;
        w_cmp_lo_we = 1'b0;
        w_cmp_hi_we = 1'b0;
        w_tohost_we = 1'b0;
        w_load_hit  = 1'b0;
        w_store_hit = 1'b0;
        if (MEM_en_i) begin
            case (w_region)
                REG_RAM: begin
                    if (w_bad_size || w_misaligned) begin
                        w_err = 1'b1;
                    end else if (w_is_load) begin
                        w_rdata    = w_ram_shifted;
                        w_load_hit = 1'b1;
                    end else begin
                        // Store echo: current contents trimmed to the store size
                        w_rdata     = w_ram_shifted & size_mask(MEM_write_i);
                        w_ram_we    = 1'b1;
                        w_store_hit = 1'b1;
                    end
                end
                REG_MMIO: begin
                    if (!w_mmio_size_ok) begin
                        w_err = 1'b1;
                    end else begin
                        case (w_offset)
                            OFF_TIME_LO, OFF_TIME_HI: begin
                                if (w_is_load) begin
                                    w_rdata = w_timer_rdata;
                                end else begin
                                    w_err = 1'b1;
                                end
                            end
                            OFF_CMP_LO: begin
                                if (w_is_load) begin
                                    w_rdata = w_timer_rdata;
                                end else begin
                                    w_cmp_lo_we = 1'b1;
                                end
                            end
                            OFF_CMP_HI: begin
                                if (w_is_load) begin
                                    w_rdata = w_timer_rdata;
                                end else begin
                                    w_cmp_hi_we = 1'b1;
                                end
                            end
                            OFF_TOHOST: begin
                                if (w_is_load) begin
                                    w_rdata = r_exit_code;
                                end else begin
                                    // Zero is not an exit request
                                    w_tohost_we = (MEM_data_i != 32'd0);
                                end
                            end
`ifdef MEM_STATS_EN
                            OFF_LOAD_CYC: begin
                                if (w_is_load) begin
                                    w_rdata = r_load_cyc;
                                end else begin
                                    w_err = 1'b1;
                                end
                            end
                            OFF_STORE_CYC: begin
                                if (w_is_load) begin
                                    w_rdata = r_store_cyc;
                                end else begin
                                    w_err = 1'b1;
                                end
                            end
`endif
                            default: begin
                                w_err = 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    w_err = 1'b1;
                end
            endcase
        end else begin
            w_err = 1'b0;
        end
    end

    // RAM byte-lane write; no reset, and a store overlapping reset is dropped
    always_ff @(posedge clk) begin
        if (!rst_i && w_ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byte_en[b]) begin
                    r_ram[w_ram_idx][8*b +: 8] <= w_wdata_shifted[8*b +: 8];
                end
            end
        end
    end

    // Error pulse, sticky done flag and exit code
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_exit_code <= 32'd0;
        end else begin
            r_err <= w_err;
            if (w_tohost_we) begin
                r_done      <= 1'b1;
                r_exit_code <= MEM_data_i;
            end
        end
    end

`ifdef MEM_STATS_EN
    // Saturating per-cycle counters of RAM load and store activity
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_load_cyc  <= 32'd0;
            r_store_cyc <= 32'd0;
        end else begin
            if (w_load_hit && (r_load_cyc != 32'hFFFF_FFFF)) begin
                r_load_cyc <= r_load_cyc + 32'd1;
            end
            if (w_store_hit && (r_store_cyc != 32'hFFFF_FFFF)) begin
                r_store_cyc <= r_store_cyc + 32'd1;
            end
        end
    end
`endif

    mmio_timer u_timer (
        .clk         (clk),
        .rst_i       (rst_i),
        .wr_lo       (w_cmp_lo_we),
        .wr_hi       (w_cmp_hi_we),
        .wdata       (MEM_data_i),
        .rd_sel      (MEM_addr_i[3:2]),
        .rdata       (w_timer_rdata),
        .timer_irq_o (timer_irq_o)
    );

    assign MEM_data_o  = w_rdata;
    assign err_o       = r_err;
    assign done_o      = r_done;
    assign exit_code_o = r_exit_code;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_i;
    logic        MEM_en_i;
    logic [31:0] MEM_addr_i;
    logic [31:0] MEM_data_i;
    logic [3:0]  MEM_write_i;
    logic [31:0] MEM_data_o;
    logic        err_o;
    logic        timer_irq_o;
    logic        done_o;
    logic [31:0] exit_code_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] MB = 32'hFFFF_0000;

    data_mem_responder dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .MEM_en_i    (MEM_en_i),
        .MEM_addr_i  (MEM_addr_i),
        .MEM_data_i  (MEM_data_i),
        .MEM_write_i (MEM_write_i),
        .MEM_data_o  (MEM_data_o),
        .err_o       (err_o),
        .timer_irq_o (timer_irq_o),
        .done_o      (done_o),
        .exit_code_o (exit_code_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one access cycle at the falling edge and let comb outputs settle
    task automatic step(input logic en, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        @(negedge clk);
        MEM_en_i    = en;
        MEM_addr_i  = a;
        MEM_data_i  = d;
        MEM_write_i = w;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i    = 1'b1;
        MEM_en_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_time;
        rst_i = 1'b1; MEM_en_i = 1'b0; MEM_addr_i = 32'd0; MEM_data_i = 32'd0; MEM_write_i = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        check("rst_data", MEM_data_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_irq", {31'd0, timer_irq_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_exit", exit_code_o, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;

        // Word store then byte-offset loads
        step(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b1111);
        step(1'b1, 32'h100, 32'd0, 4'b0000);
        check("ld_w100", MEM_data_o, 32'hDEAD_BEEF);
        check("st_w_err", {31'd0, err_o}, 32'd0);
        step(1'b1, 32'h101, 32'd0, 4'b0000);
        check("ld_b101", {24'd0, MEM_data_o[7:0]}, 32'h0000_00BE);
        check("ld_101_full", MEM_data_o, 32'h00DE_ADBE);
        step(1'b1, 32'h102, 32'd0, 4'b0000);
        check("ld_b102", {24'd0, MEM_data_o[7:0]}, 32'h0000_00AD);
        step(1'b1, 32'h103, 32'd0, 4'b0000);
        check("ld_b103", MEM_data_o, 32'h0000_00DE);

        // Byte store held three cycles; upper data bits must be ignored
        step(1'b1, 32'h102, 32'hAAAA_AA55, 4'b0001);
        step(1'b1, 32'h102, 32'hAAAA_AA55, 4'b0001);
        step(1'b1, 32'h102, 32'hAAAA_AA55, 4'b0001);
        check("st_b_echo", MEM_data_o, 32'h0000_0055);
        check("st_b_err", {31'd0, err_o}, 32'd0);
        step(1'b1, 32'h100, 32'd0, 4'b0000);
        check("ld_after_b", MEM_data_o, 32'hDE55_BEEF);
        check("st_b_err2", {31'd0, err_o}, 32'd0);

        // Aligned half store at upper half
        step(1'b1, 32'h106, 32'h1234_ABCD, 4'b0011);
        step(1'b1, 32'h104, 32'd0, 4'b0000);
        check("ld_half", MEM_data_o[31:16] == 16'hABCD ? 32'd1 : 32'd0, 32'd1);

        // Misaligned half store
        step(1'b1, 32'h101, 32'h0000_1234, 4'b0011);
        check("mis_data", MEM_data_o, 32'd0);
        step(1'b1, 32'h100, 32'd0, 4'b0000);
        check("mis_err", {31'd0, err_o}, 32'd1);
        check("mis_ram", MEM_data_o, 32'hDE55_BEEF);
        step(1'b0, 32'd0, 32'd0, 4'b0000);
        check("mis_err_clr", {31'd0, err_o}, 32'd0);

        // Unmapped load and idle cycle
        step(1'b1, 32'h0001_0000, 32'd0, 4'b0000);
        check("unm_data", MEM_data_o, 32'd0);
        step(1'b0, 32'h0001_0000, 32'd0, 4'b0000);
        check("unm_err", {31'd0, err_o}, 32'd1);
        check("idle_data", MEM_data_o, 32'd0);
        step(1'b0, 32'd0, 32'd0, 4'b0000);
        check("idle_err", {31'd0, err_o}, 32'd0);

        // Writes to TIME are refused
        step(1'b1, MB + 32'h0, 32'h5, 4'b1111);
        step(1'b0, 32'd0, 32'd0, 4'b0000);
        check("time_wr_err", {31'd0, err_o}, 32'd1);

`ifdef MEM_STATS_EN
        do_reset();
        repeat (5) step(1'b1, 32'h100, 32'd0, 4'b0000);
        repeat (3) step(1'b1, 32'h200, 32'h11, 4'b0001);
        step(1'b1, MB + 32'h14, 32'd0, 4'b0000);
        check("load_cyc", MEM_data_o, 32'd5);
        step(1'b1, MB + 32'h18, 32'd0, 4'b0000);
        check("store_cyc", MEM_data_o, 32'd3);
`else
        step(1'b1, MB + 32'h14, 32'd0, 4'b0000);
        check("stat_unm_data", MEM_data_o, 32'd0);
        step(1'b0, 32'd0, 32'd0, 4'b0000);
        check("stat_unm_err", {31'd0, err_o}, 32'd1);
`endif

        // TOHOST
        step(1'b1, MB + 32'h10, 32'd0, 4'b1111);
        step(1'b0, 32'd0, 32'd0, 4'b0000);
        check("tohost0_done", {31'd0, done_o}, 32'd0);
        check("tohost0_err", {31'd0, err_o}, 32'd0);
        step(1'b1, MB + 32'h10, 32'h2A, 4'b1111);
        step(1'b1, MB + 32'h10, 32'd0, 4'b0000);
        check("tohost_done", {31'd0, done_o}, 32'd1);
        check("tohost_exit", exit_code_o, 32'h2A);
        check("tohost_rd", MEM_data_o, 32'h2A);
        step(1'b1, MB + 32'h10, 32'h7, 4'b1111);
        step(1'b1, MB + 32'h10, 32'h9, 4'b0001);
        check("tohost_ovw", exit_code_o, 32'h7);
        check("tohost_sticky", {31'd0, done_o}, 32'd1);
        step(1'b0, 32'd0, 32'd0, 4'b0000);
        check("tohost_sub_err", {31'd0, err_o}, 32'd1);
        check("tohost_sub_ign", exit_code_o, 32'h7);
        do_reset();
        #1;
        check("rst_clr_done", {31'd0, done_o}, 32'd0);
        check("rst_clr_exit", exit_code_o, 32'd0);

        // Timer compare: CMP_HI=0 in the reset-release cycle, CMP_LO=20 next
        @(negedge clk);
        rst_i = 1'b1;
        MEM_en_i = 1'b0;
        @(negedge clk);
        rst_i       = 1'b0;
        MEM_en_i    = 1'b1;
        MEM_addr_i  = MB + 32'h0C;
        MEM_data_i  = 32'd0;
        MEM_write_i = 4'b1111;
        step(1'b1, MB + 32'h08, 32'd20, 4'b1111);
        exp_time = 32'd2;
        for (int i = 0; i < 25; i++) begin
            step(1'b1, MB + 32'h00, 32'd0, 4'b0000);
            check("time_lo", MEM_data_o, exp_time);
            check("irq", {31'd0, timer_irq_o}, (exp_time >= 32'd21) ? 32'd1 : 32'd0);
            exp_time = exp_time + 32'd1;
        end
        step(1'b1, MB + 32'h08, 32'd0, 4'b0000);
        check("cmp_lo_rd", MEM_data_o, 32'd20);
        do_reset();
        #1;
        check("irq_rst", {31'd0, timer_irq_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
